// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : cpu_control_fsm
// Brief   : Multi-cycle fetch/decode/execute/memory sequencer for the 18-bit
//           CPU, with compare-flag register and memory-port timeout.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_control_fsm #(
    parameter int IW          = 18,
    parameter int MEM_TIMEOUT = 16,
    parameter int TOW         = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr,
    input  logic          mem_ready,
    input  logic          cmp_eq,
    input  logic          cmp_above,
    input  logic          cmp_below,
    output logic          mem_req,
    output logic          mem_we,
    output logic          addr_sel,
    output logic          ir_load,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          pc_clr,
    output logic [1:0]    alu_op,
    output logic          alu_src_imm,
    output logic          reg_we,
    output logic          wb_sel,
    output logic [2:0]    flags,
    output logic          fault
);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_NAND = 4'h3;
    localparam logic [3:0] c_OP_NOR  = 4'h4;
    localparam logic [3:0] c_OP_ADDI = 4'h5;
    localparam logic [3:0] c_OP_ANDI = 4'h6;
    localparam logic [3:0] c_OP_LD   = 4'h7;
    localparam logic [3:0] c_OP_ST   = 4'h8;
    localparam logic [3:0] c_OP_CMP  = 4'h9;
    localparam logic [3:0] c_OP_JE   = 4'hA;
    localparam logic [3:0] c_OP_JA   = 4'hB;
    localparam logic [3:0] c_OP_JB   = 4'hC;
    localparam logic [3:0] c_OP_JAE  = 4'hD;
    localparam logic [3:0] c_OP_JBE  = 4'hE;
    localparam logic [3:0] c_OP_RST  = 4'hF;

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_FAULT  = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [TOW-1:0] r_count;
    logic [2:0]     r_flags;
    logic [3:0]     w_opcode;
    logic           w_timeout;
    logic           w_mem_phase;
    logic           w_jump_taken;
    logic           w_unused;

    assign w_opcode    = instr[IW-1 -: 4];
    assign w_unused    = ^instr[IW-5:0];
    assign w_timeout   = (r_count == TOW'(MEM_TIMEOUT - 1));
    assign w_mem_phase = (r_state == c_FETCH) || (r_state == c_MEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH: begin
                if (mem_ready) begin
                    w_next = c_DECODE;
                end else if (w_timeout) begin
                    w_next = c_FAULT;
                end
            end
            c_DECODE: w_next = c_EXEC;
            c_EXEC: begin
                if ((w_opcode == c_OP_LD) || (w_opcode == c_OP_ST)) begin
                    w_next = c_MEM;
                end else begin
                    w_next = c_FETCH;
                end
            end
            c_MEM: begin
                if (mem_ready) begin
                    w_next = c_FETCH;
                end else if (w_timeout) begin
                    w_next = c_FAULT;
                end
            end
            c_FAULT: w_next = c_FAULT;
            default: w_next = c_FETCH;
        endcase
    end

    // Any state change restarts the wait count, so each FETCH/MEM visit gets a full budget.
    always_ff @(posedge clk) begin
        if (rst || (w_next != r_state)) begin
            r_count <= '0;
        end else if (w_mem_phase && !mem_ready) begin
            r_count <= r_count + TOW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (r_state == c_EXEC) begin
            if (w_opcode == c_OP_CMP) begin
                r_flags <= {cmp_eq, cmp_above, cmp_below};
            end else if (w_opcode == c_OP_RST) begin
                r_flags <= 3'b000;
            end
        end
    end

    // Jump conditions read the latched flags only; live comparator inputs are ignored.
    always_comb begin
        case (w_opcode)
            c_OP_JE:  w_jump_taken = r_flags[2];
            c_OP_JA:  w_jump_taken = r_flags[1];
            c_OP_JB:  w_jump_taken = r_flags[0];
            c_OP_JAE: w_jump_taken = r_flags[2] | r_flags[1];
            c_OP_JBE: w_jump_taken = r_flags[2] | r_flags[0];
            default:  w_jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_clr      = 1'b0;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        flags       = 3'b000;
        fault       = 1'b0;
        if (!rst) begin
            flags = r_flags;
            case (r_state)
                c_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                    end
                end
                c_EXEC: begin
                    case (w_opcode)
                        c_OP_ADD:  reg_we = 1'b1;
                        c_OP_AND: begin
                            alu_op = 2'b01;
                            reg_we = 1'b1;
                        end
                        c_OP_NAND: begin
                            alu_op = 2'b10;
                            reg_we = 1'b1;
                        end
                        c_OP_NOR: begin
                            alu_op = 2'b11;
                            reg_we = 1'b1;
                        end
                        c_OP_ADDI: begin
                            alu_src_imm = 1'b1;
                            reg_we      = 1'b1;
                        end
                        c_OP_ANDI: begin
                            alu_op      = 2'b01;
                            alu_src_imm = 1'b1;
                            reg_we      = 1'b1;
                        end
                        c_OP_JE, c_OP_JA, c_OP_JB, c_OP_JAE, c_OP_JBE:
                            pc_load = w_jump_taken;
                        c_OP_RST:  pc_clr = 1'b1;
                        default: ;
                    endcase
                end
                c_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (w_opcode == c_OP_ST);
                    if (mem_ready && (w_opcode == c_OP_LD)) begin
                        reg_we = 1'b1;
                        wb_sel = 1'b1;
                    end
                end
                c_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
